// File: rtl/ula_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ula_pkg
// Brief   : Opcode encodings and default operand width for the ula ALU.
// Revision: 1.0
// ============================================================================
package ula_pkg;

  localparam int ULA_WIDTH = 4;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_SHL = 4'h4;
  localparam logic [3:0] OP_SHR = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_NOT = 4'h9;

endpackage
`default_nettype wire

// File: rtl/ula_divider.sv
`default_nettype none
// ============================================================================
// Module  : ula_divider
// Brief   : Combinational restoring divider; quotient is zero for a zero divisor.
// Revision: 1.0
// ============================================================================
module ula_divider
  import ula_pkg::*;
#(
  parameter int WIDTH = ULA_WIDTH
) (
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] w_rem [0:WIDTH];
  logic [WIDTH-1:0] w_q;

  assign w_rem[0] = '0;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
      logic [WIDTH:0]   w_shift;
      logic [WIDTH-1:0] w_sub;
      logic             w_ge;

      assign w_shift = {w_rem[i], dividend[WIDTH-1-i]};
      assign w_ge    = (w_shift >= {1'b0, divisor});
      // When the subtraction is taken the true result is below the divisor,
      // so the low WIDTH bits of the difference are exact.
      assign w_sub   = w_shift[WIDTH-1:0] - divisor;

      assign w_rem[i+1]        = w_ge ? w_sub : w_shift[WIDTH-1:0];
      assign w_q[WIDTH-1-i]    = w_ge;
    end
  endgenerate

  assign quotient  = (divisor == '0) ? '0 : w_q;
  assign remainder = w_rem[WIDTH];

endmodule
`default_nettype wire

// File: rtl/ula.sv
`default_nettype none
// ============================================================================
// Module  : ula
// Brief   : Opcode-selected ALU on two unsigned operands, one-cycle registered result.
// Revision: 1.0
// ============================================================================
module ula
  import ula_pkg::*;
#(
  parameter int WIDTH = ULA_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           switchs,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   saida
);

  localparam int RW = 2 * WIDTH;

  logic [RW-1:0]    w_a;
  logic [RW-1:0]    w_b;
  logic [RW-1:0]    w_result;
  logic [WIDTH-1:0] w_quot;
  logic [WIDTH-1:0] w_div_rem_unused;
  logic [RW-1:0]    r_saida;

  assign w_a = {{WIDTH{1'b0}}, A};
  assign w_b = {{WIDTH{1'b0}}, B};

  ula_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .dividend  (A),
    .divisor   (B),
    .quotient  (w_quot),
    .remainder (w_div_rem_unused)
  );

  // Reserved opcodes fall through to zero so the output is always defined.
  always_comb begin
    w_result = '0;
    case (switchs)
      OP_ADD: w_result = w_a + w_b;
      OP_SUB: w_result = w_a - w_b;
      OP_MUL: w_result = w_a * w_b;
      OP_DIV: w_result = {{WIDTH{1'b0}}, w_quot};
      OP_SHL: w_result = {{WIDTH{1'b0}}, A[WIDTH-2:0], 1'b0};
      OP_SHR: w_result = {{WIDTH{1'b0}}, 1'b0, A[WIDTH-1:1]};
      OP_AND: w_result = {{WIDTH{1'b0}}, A & B};
      OP_OR:  w_result = {{WIDTH{1'b0}}, A | B};
      OP_XOR: w_result = {{WIDTH{1'b0}}, A ^ B};
      OP_NOT: w_result = {{WIDTH{1'b0}}, ~A};
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_saida <= '0;
    end else begin
      r_saida <= w_result;
    end
  end

  assign saida = r_saida;

endmodule
`default_nettype wire

// File: tb/tb_ula.sv
`default_nettype none
// ============================================================================
// Module  : tb_ula
// Brief   : Self-checking bench for ula: directed vector table plus corner sequences.
// Revision: 1.0
// ============================================================================
module tb_ula;
  import ula_pkg::*;

  typedef struct {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] switchs = 4'h0;
  logic [3:0] A = 4'h0;
  logic [3:0] B = 4'h0;
  logic [7:0] saida;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[$];

  always #5 clk = ~clk;

  ula #(.WIDTH(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .switchs (switchs),
    .A       (A),
    .B       (B),
    .saida   (saida)
  );

  function automatic logic [7:0] model(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] ea;
    logic [7:0] eb;
    ea = {4'h0, a};
    eb = {4'h0, b};
    case (op)
      4'h0: return ea + eb;
      4'h1: return ea - eb;
      4'h2: return ea * eb;
      4'h3: return (b == 4'h0) ? 8'h00 : (ea / eb);
      4'h4: return {4'h0, a[2:0], 1'b0};
      4'h5: return {5'h00, a[3:1]};
      4'h6: return ea & eb;
      4'h7: return ea | eb;
      4'h8: return ea ^ eb;
      4'h9: return {4'h0, ~a};
      default: return 8'h00;
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: saida=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic apply(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    switchs = op;
    A = a;
    B = b;
    @(posedge clk);
    #1;
  endtask

  function automatic void add_vec(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.exp = exp;
    vecs.push_back(v);
  endfunction

  initial begin
    // Directed vectors with hand-computed results.
    add_vec(OP_ADD, 4'd0,  4'd0,  8'h00);
    add_vec(OP_ADD, 4'd8,  4'd15, 8'h17);
    add_vec(OP_ADD, 4'd15, 4'd15, 8'h1E);
    add_vec(OP_SUB, 4'd8,  4'd4,  8'h04);
    add_vec(OP_SUB, 4'd2,  4'd3,  8'hFF);
    add_vec(OP_SUB, 4'd1,  4'd4,  8'hFD);
    add_vec(OP_SUB, 4'd4,  4'd4,  8'h00);
    add_vec(OP_MUL, 4'd8,  4'd0,  8'h00);
    add_vec(OP_MUL, 4'd8,  4'd8,  8'h40);
    add_vec(OP_MUL, 4'd15, 4'd1,  8'h0F);
    add_vec(OP_MUL, 4'd15, 4'd15, 8'hE1);
    add_vec(OP_DIV, 4'd8,  4'd2,  8'h04);
    add_vec(OP_DIV, 4'd2,  4'd2,  8'h01);
    add_vec(OP_DIV, 4'd9,  4'd1,  8'h09);
    add_vec(OP_DIV, 4'd1,  4'd0,  8'h00);
    add_vec(OP_DIV, 4'd15, 4'd4,  8'h03);
    add_vec(OP_SHL, 4'b1010, 4'd7, 8'h04);
    add_vec(OP_SHL, 4'b1111, 4'd0, 8'h0E);
    add_vec(OP_SHL, 4'b0000, 4'd9, 8'h00);
    add_vec(OP_SHL, 4'b1000, 4'd3, 8'h00);
    add_vec(OP_SHR, 4'b1010, 4'd7, 8'h05);
    add_vec(OP_SHR, 4'b1111, 4'd0, 8'h07);
    add_vec(OP_SHR, 4'b0000, 4'd9, 8'h00);
    add_vec(OP_SHR, 4'b0001, 4'd3, 8'h00);
    add_vec(OP_AND, 4'b1100, 4'b1010, 8'h08);
    add_vec(OP_OR,  4'b1100, 4'b1010, 8'h0E);
    add_vec(OP_XOR, 4'b1100, 4'b1010, 8'h06);
    add_vec(OP_NOT, 4'b1100, 4'b1010, 8'h03);
    for (int r = 10; r < 16; r++) begin
      add_vec(4'(r), 4'b1100, 4'b1010, 8'h00);
    end

    // Asynchronous reset assertion before any clock edge.
    switchs = OP_ADD; A = 4'd7; B = 4'd7;
    #2 rst_n = 1'b0;
    #1 check("reset_async", saida, 8'h00);
    @(posedge clk); @(posedge clk); #1;
    check("reset_held", saida, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    apply(OP_ADD, 4'd4, 4'd1);
    check("reset_release_add", saida, 8'h05);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].op, vecs[i].a, vecs[i].b);
      n_checks++;
      if (saida !== vecs[i].exp) begin
        n_fail++;
        $display("FAIL vec%0d op=%h a=%h b=%h: saida=%h expected=%h",
                 i, vecs[i].op, vecs[i].a, vecs[i].b, saida, vecs[i].exp);
      end
    end

    // Inputs changed between edges must not reach saida before the next edge.
    apply(OP_ADD, 4'd3, 4'd4);
    check("latency_first", saida, 8'h07);
    @(negedge clk);
    switchs = OP_MUL; A = 4'd15; B = 4'd15;
    #1 check("latency_hold", saida, 8'h07);
    @(posedge clk); #1;
    check("latency_update", saida, 8'hE1);

    // Reset mid-cycle clears immediately; first edge after release loads inputs.
    @(negedge clk);
    switchs = OP_SUB; A = 4'd2; B = 4'd3;
    #1 rst_n = 1'b0;
    #1 check("reset_midcycle", saida, 8'h00);
    @(posedge clk); #1;
    check("reset_mid_held", saida, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("reset_first_edge", saida, 8'hFF);

    // All opcode/operand combinations in a randomly rotated order.
    begin
      int base;
      base = int'($urandom_range(0, 4095));
      for (int k = 0; k < 4096; k++) begin
        logic [11:0] idx;
        idx = 12'(k ^ base);
        apply(idx[11:8], idx[7:4], idx[3:0]);
        n_checks++;
        if (saida !== model(idx[11:8], idx[7:4], idx[3:0])) begin
          n_fail++;
          $display("FAIL sweep op=%h a=%h b=%h: saida=%h expected=%h",
                   idx[11:8], idx[7:4], idx[3:0], saida,
                   model(idx[11:8], idx[7:4], idx[3:0]));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
